// File: rtl/spi_master_seq_pkg.sv
// spi_ctrl_pkg: control-word field positions and sequencer state encoding
// shared by the SPI master sequencer files.
package spi_ctrl_pkg;
    localparam int CTRL_SEND  = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_N_LSB = 8;
    localparam int CTRL_N_MSB = 15;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE, SETTLE} state_t;
endpackage

// File: rtl/spi_master_seq_if.sv
// spi_master_seq_if: control-register, data-store and SPI pad signals of the sequencer.
interface spi_master_seq_if #(parameter int CNT_W = 8);
    logic [31:0]      ctrl_in;
    logic             o_wr2c;
    logic             o_flag;
    logic             o_new;
    logic [CNT_W-1:0] tx_addr;
    logic [7:0]       tx_byte;
    logic             rx_we;
    logic [CNT_W-1:0] rx_addr;
    logic [7:0]       rx_byte;
    logic             cs_n;
    logic             sclk;
    logic             mosi;
    logic             miso;
    modport master (
        input  ctrl_in, tx_byte, miso,
        output o_wr2c, o_flag, o_new, tx_addr, rx_we, rx_addr, rx_byte, cs_n, sclk, mosi
    );
    modport slave (
        output ctrl_in, tx_byte, miso,
        input  o_wr2c, o_flag, o_new, tx_addr, rx_we, rx_addr, rx_byte, cs_n, sclk, mosi
    );
endinterface

// File: rtl/spi_master_seq_shifter.sv
// spi_byte_shifter: one mode-0 SPI byte, MSB first; sclk half-period is CLK_DIV clocks,
// done is high on the last clock of the 16th half-period.
module spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx_byte
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic          active;
    logic [DW-1:0] cnt;
    logic [3:0]    half;
    logic [7:0]    sh;
    logic          tick;
    assign tick = active && cnt == DW'(CLK_DIV - 1);
    assign done = tick && half == 4'd15;
    assign mosi = sh[7];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            half    <= '0;
            sh      <= '0;
            sclk    <= 1'b0;
            rx_byte <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            half   <= '0;
            sh     <= tx_byte;
            sclk   <= 1'b0;
        end else if (active) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                sclk <= ~sclk;
                half <= half + 1'b1;
                // low-to-high edge samples miso; high-to-low edge presents the next bit
                if (!sclk) rx_byte <= {rx_byte[6:0], miso};
                else sh <= {sh[6:0], 1'b0};
            end
            if (done) active <= 1'b0;
        end
    end
endmodule

// File: rtl/spi_master_seq.sv
// spi_master_seq: on a send request streams N+1 bytes from the TX store over SPI,
// writes each received byte to the RX store and posts busy/done to the control register.
module spi_master_seq
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    spi_master_seq_if.master bus
);
    state_t           state, nxt;
    logic [CNT_W-1:0] idx, n;
    logic [7:0]       rx_shift;
    logic             done, start, go;
    logic             ctrl_unused;
    assign ctrl_unused = ^{bus.ctrl_in[31:CTRL_N_MSB+1], bus.ctrl_in[CTRL_N_LSB-1:CTRL_BUSY]};
    assign bus.tx_addr = idx;
    assign go = state == IDLE && bus.ctrl_in[CTRL_SEND];
    assign start = state == LOAD;
    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_byte (bus.tx_byte),
        .miso    (bus.miso),
        .sclk    (bus.sclk),
        .mosi    (bus.mosi),
        .done    (done),
        .rx_byte (rx_shift)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? LOAD : IDLE;
            LOAD:    nxt = SHIFT;
            SHIFT:   nxt = done ? STORE : SHIFT;
            STORE:   nxt = idx == n ? DONE : LOAD;
            DONE:    nxt = SETTLE;
            default: nxt = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            n           <= '0;
            bus.cs_n    <= 1'b1;
            bus.o_wr2c  <= 1'b0;
            bus.o_flag  <= 1'b0;
            bus.o_new   <= 1'b0;
            bus.rx_we   <= 1'b0;
            bus.rx_addr <= '0;
            bus.rx_byte <= '0;
        end else begin
            state      <= nxt;
            bus.cs_n   <= !(nxt inside {LOAD, SHIFT, STORE});
            bus.o_wr2c <= go || state == DONE;
            bus.o_flag <= go;
            bus.o_new  <= go;
            bus.rx_we  <= nxt == STORE;
            if (nxt == STORE) begin
                bus.rx_addr <= idx;
                bus.rx_byte <= rx_shift;
            end
            if (go) begin
                n   <= CNT_W'(bus.ctrl_in[CTRL_N_MSB:CTRL_N_LSB]);
                idx <= '0;
            end else if (state == STORE && idx != n) begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: directed checks of the SPI sequencer at CLK_DIV=4 and CLK_DIV=1,
// with a small control-register model applying the wr2c write-backs.
module tb_spi_master_seq;
    logic clk = 1'b0;
    logic rst;
    logic sel, loop, drop;
    logic [7:0] tx_mem [256];
    int checks = 0, failures = 0, cycle = 0;
    logic pend_a, pend_b;
    logic [1:0] val_a, val_b;
    logic prev_sclk, prev_csn;
    int rises, we_n, wr_n, csn_fall, csn_rise, we_cyc, c0;
    int rise_cyc [2];
    int wr_cyc [4];
    logic [1:0] wr_val [4];
    logic [7:0] we_addr [4];
    logic [7:0] we_data [4];
    logic [31:0] mosi_bits;
    logic m_sclk, m_mosi, m_csn, m_we, m_wr2c, m_flag, m_new;
    logic [7:0] m_addr, m_data;

    spi_master_seq_if #(.CNT_W(8)) a ();
    spi_master_seq_if #(.CNT_W(8)) b ();
    spi_master_seq #(.CLK_DIV(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(a));
    spi_master_seq #(.CLK_DIV(1), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;
    assign a.tx_byte = tx_mem[a.tx_addr];
    assign b.tx_byte = tx_mem[b.tx_addr];
    assign a.miso = loop ? a.mosi : 1'b0;
    assign b.miso = loop ? b.mosi : 1'b0;
    assign m_sclk = sel ? b.sclk : a.sclk;
    assign m_mosi = sel ? b.mosi : a.mosi;
    assign m_csn  = sel ? b.cs_n : a.cs_n;
    assign m_we   = sel ? b.rx_we : a.rx_we;
    assign m_addr = sel ? b.rx_addr : a.rx_addr;
    assign m_data = sel ? b.rx_byte : a.rx_byte;
    assign m_wr2c = sel ? b.o_wr2c : a.o_wr2c;
    assign m_flag = sel ? b.o_flag : a.o_flag;
    assign m_new  = sel ? b.o_new : a.o_new;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rises = 0; we_n = 0; wr_n = 0; csn_fall = 0; csn_rise = 0; mosi_bits = '0; we_cyc = 0;
    endtask

    // One clock: control register takes last cycle's write-back, then monitors sample.
    task automatic cyc();
        @(negedge clk);
        if (pend_a) a.ctrl_in[1:0] = val_a;
        if (pend_b) b.ctrl_in[1:0] = val_b;
        pend_a = a.o_wr2c && !drop;
        val_a = {a.o_flag, a.o_new};
        pend_b = b.o_wr2c;
        val_b = {b.o_flag, b.o_new};
        cycle++;
        if (m_sclk && !prev_sclk) begin
            if (rises < 2) rise_cyc[rises] = cycle;
            rises++;
            mosi_bits = {mosi_bits[30:0], m_mosi};
        end
        prev_sclk = m_sclk;
        if (m_we) begin
            if (we_n < 4) begin
                we_addr[we_n] = m_addr;
                we_data[we_n] = m_data;
            end
            we_cyc = cycle;
            we_n++;
        end
        if (m_wr2c) begin
            if (wr_n < 4) begin
                wr_val[wr_n] = {m_flag, m_new};
                wr_cyc[wr_n] = cycle;
            end
            wr_n++;
        end
        if (m_csn && !prev_csn) csn_rise++;
        if (!m_csn && prev_csn) csn_fall++;
        prev_csn = m_csn;
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; loop = 1'b1; drop = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0; val_a = '0; val_b = '0;
        prev_sclk = 1'b0; prev_csn = 1'b1;
        a.ctrl_in = '0; b.ctrl_in = '0;
        for (int i = 0; i < 256; i++) tx_mem[i] = '0;
        clr();
        repeat (3) cyc();
        chk("rst_cs_n", 32'(a.cs_n), 1);
        chk("rst_sclk_mosi", 32'({a.sclk, a.mosi}), 0);
        chk("rst_strobes", 32'({a.o_wr2c, a.o_flag, a.o_new, a.rx_we}), 0);
        chk("rst_rx", 32'({a.rx_addr, a.rx_byte}), 0);
        chk("rst_tx_addr", 32'(a.tx_addr), 0);
        rst = 1'b1;
        repeat (2) cyc();

        // one byte, loopback, CLK_DIV=4
        tx_mem[0] = 8'hA5;
        clr(); c0 = cycle; a.ctrl_in = 32'h0000_0001;
        repeat (80) cyc();
        chk("a_wr_n", 32'(wr_n), 2);
        chk("a_wr_start", 32'(wr_val[0]), 3);
        chk("a_wr_end", 32'(wr_val[1]), 0);
        chk("a_start_lat", 32'(wr_cyc[0] - c0), 1);
        chk("a_settle_lat", 32'(wr_cyc[1] - c0), 68);
        chk("a_rises", 32'(rises), 8);
        chk("a_mosi", mosi_bits, 32'hA5);
        chk("a_we_n", 32'(we_n), 1);
        chk("a_we", 32'({we_addr[0], we_data[0]}), 32'h00A5);
        chk("a_ctrl", 32'(a.ctrl_in[1:0]), 0);
        chk("a_cs_edges", 32'({csn_fall[3:0], csn_rise[3:0]}), 32'h11);

        // three bytes, miso tied low
        loop = 1'b0;
        tx_mem[0] = 8'h01; tx_mem[1] = 8'h80; tx_mem[2] = 8'hFF;
        clr(); a.ctrl_in = 32'h0000_0201;
        repeat (220) cyc();
        chk("b_we_n", 32'(we_n), 3);
        chk("b_we_addr", 32'({we_addr[0], we_addr[1], we_addr[2]}), 32'h000102);
        chk("b_we_data", 32'({we_data[0], we_data[1], we_data[2]}), 0);
        chk("b_mosi", mosi_bits, 32'h0180FF);
        chk("b_cs_edges", 32'({csn_fall[3:0], csn_rise[3:0]}), 32'h11);
        chk("b_ctrl", 32'(a.ctrl_in[1:0]), 0);

        // CLK_DIV=1: sclk period 2 clocks, 16 SHIFT cycles between LOAD and STORE
        sel = 1'b1; loop = 1'b1; tx_mem[0] = 8'h3C;
        clr(); c0 = cycle; b.ctrl_in = 32'h0000_0001;
        repeat (30) cyc();
        chk("c_sclk_period", 32'(rise_cyc[1] - rise_cyc[0]), 2);
        chk("c_mosi", mosi_bits, 32'h3C);
        chk("c_we_data", 32'(we_data[0]), 32'h3C);
        chk("c_shift_cycles", 32'(we_cyc - wr_cyc[0] - 1), 16);
        chk("c_settle_lat", 32'(wr_cyc[1] - c0), 20);
        sel = 1'b0;

        // N changed mid-transfer is ignored
        tx_mem[0] = 8'h11; tx_mem[1] = 8'h22;
        clr(); a.ctrl_in = 32'h0000_0101;
        repeat (20) cyc();
        a.ctrl_in[15:8] = 8'd7;
        repeat (200) cyc();
        chk("d_we_n", 32'(we_n), 2);
        chk("d_wr_n", 32'(wr_n), 2);

        // dropped completion write-back leaves send set: restart right after SETTLE
        drop = 1'b1; tx_mem[0] = 8'h5A;
        clr(); a.ctrl_in = 32'h0000_0001;
        repeat (70) cyc();
        drop = 1'b0; a.ctrl_in = '0;
        repeat (90) cyc();
        chk("e_wr_n", 32'(wr_n), 4);
        chk("e_restart", 32'(wr_cyc[2] - wr_cyc[1]), 2);
        chk("e_we_n", 32'(we_n), 2);
        clr();
        repeat (20) cyc();
        chk("e_idle", 32'({wr_n[3:0], csn_fall[3:0], 3'b0, a.cs_n}), 32'h001);

        // asynchronous reset in the middle of SHIFT
        clr(); a.ctrl_in = 32'h0000_0001;
        repeat (23) cyc();
        chk("f_sclk_pre", 32'(a.sclk), 1);
        a.ctrl_in = '0;
        #2 rst = 1'b0;
        #1;
        chk("f_cs_n", 32'(a.cs_n), 1);
        chk("f_sclk", 32'(a.sclk), 0);
        chk("f_strobes", 32'({a.o_wr2c, a.o_flag, a.o_new, a.rx_we}), 0);
        repeat (2) cyc();
        rst = 1'b1;
        clr();
        repeat (100) cyc();
        chk("f_after", 32'({wr_n[3:0], we_n[3:0], csn_fall[3:0]}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- SPI-master sequencer; the consumer end of the control register.
- Watches the 32-bit control word. On a send request it transfers (N+1) bytes from the TX data store out on MOSI and writes each received MISO byte to the RX data store.
- Reports busy/done back to the control register through its second write port: wr2c, flag and new.
- Sits between the control/data registers and the SPI pads.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period, minimum 1.
- CNT_W, 8: width of byte count and index; matches control field [15:8].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ctrl_in  in  32  control register contents: [0] send, [1] busy, [15:8] N = bytes-1
- o_wr2c  out  1  one-cycle write strobe to control register port 2
- o_flag  out  1  value for control bit 1 (busy)
- o_new  out  1  value for control bit 0 (send)
- tx_addr  out  CNT_W  TX store read address (current byte index)
- tx_byte  in  8  TX store read data, combinational from tx_addr
- rx_we  out  1  one-cycle RX store write strobe
- rx_addr  out  CNT_W  RX store write address
- rx_byte  out  8  received byte
- cs_n  out  1  SPI chip select, active low
- sclk  out  1  SPI clock, mode 0 (idle low)
- mosi  out  1  SPI data out, MSB first
- miso  in  1  SPI data in

Behaviour:
- Reset (rst=0, async): state=IDLE, cs_n=1, sclk=0, mosi=0, o_wr2c=0, o_flag=0, o_new=0, rx_we=0, rx_addr=0, rx_byte=0, tx_addr=0, idx=0, n=0.
- Reset mid-transfer: the transfer is abandoned immediately and no write-back is issued.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE, SETTLE.
- IDLE:
  - cs_n=1, sclk=0.
  - If ctrl_in[0]=1: latch n=ctrl_in[15:8], set idx=0, and pulse o_wr2c with o_flag=1, o_new=1 (busy set, send held). Go to LOAD.
- LOAD:
  - tx_addr=idx, cs_n=0.
  - shift_reg <= tx_byte. Go to SHIFT.
- SHIFT (mode 0):
  - mosi = shift_reg[7].
  - sclk toggles every CLK_DIV cycles.
  - On each rising sclk edge, sample miso into the LSB of rx_shift.
  - On each falling sclk edge, shift shift_reg left.
  - After 16 half-periods (16*CLK_DIV cycles), sclk ends low. Go to STORE.
- STORE:
  - Pulse rx_we for 1 cycle with rx_addr=idx and rx_byte=rx_shift.
  - If idx==n, go to DONE. Otherwise idx++ and go to LOAD.
  - cs_n stays low between bytes.
- DONE:
  - cs_n=1.
  - Pulse o_wr2c with o_flag=0, o_new=0 (clear busy and send). Go to SETTLE.
- SETTLE: one idle cycle so the control register updates before IDLE re-samples send. Go to IDLE.
- Latency for 1 byte: 1 (IDLE) + 1 (LOAD) + 16*CLK_DIV + 1 (STORE) + 1 (DONE) + 1 (SETTLE). At CLK_DIV=4 this is 69 cycles from send seen to return to IDLE.
- Byte count:
  - n=0 transfers 1 byte; n=255 transfers 256 bytes.
  - idx is compared to n before increment, so it never wraps.
- ctrl_in changes during a transfer are ignored, because n is latched at start.
- The control register gives its port 1 (software) priority over wr2c.
  - If software writes in the DONE cycle, the clear is lost and send may remain 1.
  - In that case the block restarts a new transfer after SETTLE. Software must not write control while busy=1.
- o_flag/o_new are meaningful only while o_wr2c=1 and are held 0 otherwise.
- All outputs are registered except tx_addr, which equals idx.

Decomposition:
- Package spi_ctrl_pkg:
  - CTRL_SEND=0, CTRL_BUSY=1, CTRL_N_LSB=8, CTRL_N_MSB=15
  - FSM state encoding
- Sub-module spi_byte_shifter: SCLK divider, 8-bit TX/RX shift registers, start/done handshake.
- spi_master_seq holds the FSM, index/count and register/store strobes.

Test Plan:
- Reset asserted mid-SHIFT -> cs_n=1, sclk=0 and all strobes 0 asynchronously; no o_wr2c after reset release.
- ctrl_in=32'h0000_0001 (n=0), tx[0]=8'hA5, miso loops back mosi -> MOSI bits 1,0,1,0,0,1,0,1 on rising sclk edges; rx_we once with rx_addr=0, rx_byte=8'hA5; o_wr2c pulses (flag=1,new=1) at start and (0,0) at end; 69 cycles at CLK_DIV=4.
- ctrl_in n=2, tx={8'h01,8'h80,8'hFF}, miso tied 0 -> 3 rx_we pulses at addr 0,1,2 with data 8'h00; cs_n low continuously from first LOAD to DONE.
- CLK_DIV=1, n=0 -> sclk period 2 clk; STORE reached 16 cycles after LOAD.
- ctrl_in changed to n=7 mid-transfer of n=1 -> exactly 2 bytes transferred.
- send left at 1 after DONE (write-back dropped) -> new transfer starts 1 cycle after SETTLE; with send=0, the block stays in IDLE with cs_n=1.
